// File: rtl/tribus_pkg.sv
// ----------------------------------------------------------------------------
// tribus_pkg
// Shared definitions for the tri-state bus arbiter family.
//   - state_t  : arbiter FSM states (IDLE, GRANT, TURN), 2-bit encoding
//   - DEF_*    : default requester count and hold limit
//   - rotl     : rotate-left helper used by rr_picker to bring the
//                round-robin pointer position down to bit 0
// ----------------------------------------------------------------------------
package tribus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_HOLD_MAX = 4;
    localparam int DEF_ID_W     = 2;

    // Largest requester count the helper has to cope with.
    localparam int MAX_REQ = 8;

    // Rotate the low n bits of v left by sh positions. Bits at or above n
    // come back as zero, so the caller can pad a narrow vector to 8 bits.
    function automatic logic [MAX_REQ-1:0] rotl(input logic [MAX_REQ-1:0] v,
                                                input int unsigned       sh,
                                                input int unsigned       n);
        logic [MAX_REQ-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                r[3'((i + sh) % n)] = v[3'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tribus_arbiter_if.sv
// ----------------------------------------------------------------------------
// tribus_arbiter_if
// Request/enable bundle between the requesters and the bus arbiter.
//   req    : per-requester level request         (requester -> arbiter)
//   done   : per-requester release pulse         (requester -> arbiter)
//   en     : one-hot tri-state buffer enables    (arbiter -> requesters)
//   gnt_id : index of current owner, valid while busy
//   busy   : some enable is high
//   turn   : one-cycle idle turnaround between owners
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface tribus_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] en;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;
    logic             turn;

    modport master (
        output req,
        output done,
        input  en,
        input  gnt_id,
        input  busy,
        input  turn
    );

    modport slave (
        input  req,
        input  done,
        output en,
        output gnt_id,
        output busy,
        output turn
    );

endinterface

// File: rtl/rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches req starting at position ptr
// and wrapping around; reports the first set bit.
//   req    [N_REQ] : request vector
//   ptr    [ID_W]  : highest-priority position for this search
//   found          : at least one request is set
//   winner [ID_W]  : index of the selected requester (0 when none)
// ----------------------------------------------------------------------------
module rr_picker
    import tribus_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  winner
);

    logic [MAX_REQ-1:0] padded;
    logic [MAX_REQ-1:0] rot;

    // Rotate the request vector so that req[ptr] lands in bit 0, then take
    // the lowest set bit. Scanning downwards lets the lowest index overwrite
    // any higher one, which gives the priority order ptr, ptr+1, ...
    always_comb begin
        padded                = '0;
        padded[N_REQ-1:0]     = req;
        rot                   = rotl(padded, N_REQ - int'(ptr), N_REQ);
        found                 = |req;
        winner                = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[3'(j)]) begin
                winner = ID_W'((int'(ptr) + j) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// ----------------------------------------------------------------------------
// tribus_arbiter
// Round-robin owner selection for a 4-bit tri-state bus shared by N_REQ
// requesters. Produces registered one-hot buffer enables and inserts one
// idle turnaround cycle between successive owners so no two buffers ever
// fight on the bus.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : tribus_arbiter_if.slave (req/done in, en/gnt_id/busy/turn out)
// Parameters:
//   N_REQ    : requester count (2..8)
//   HOLD_MAX : longest single grant in cycles (>= 1)
//   ID_W     : width of gnt_id, clog2(N_REQ)
// ----------------------------------------------------------------------------
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int HOLD_MAX = DEF_HOLD_MAX,
    parameter int ID_W     = DEF_ID_W
) (
    input  logic          clk,
    input  logic          reset,
    tribus_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] en_q;
    logic [ID_W-1:0]  gnt_id_q;
    logic             busy_q;
    logic             turn_q;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic             release_now;
    logic [ID_W-1:0]  next_ptr;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req    (bus.req),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    // Release conditions for the current owner. Only the owner's own done
    // and req bits matter; everyone else's done is simply never looked at.
    // The pointer moves one past the owner so it gets lowest priority next.
    always_comb begin
        release_now = bus.done[gnt_id_q] | ~bus.req[gnt_id_q]
                    | (cnt == CNT_W'(HOLD_MAX));
        next_ptr    = (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
    end

    // Single registered FSM. Every output is a flop so nothing from req
    // reaches the buffer enables combinationally. A grant from IDLE or TURN
    // loads cnt=1, so reaching cnt==HOLD_MAX means the enable has been high
    // for exactly HOLD_MAX cycles. Leaving GRANT always passes through TURN,
    // which is what guarantees the high-Z gap between owners.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            en_q     <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            turn_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state    <= ST_GRANT;
                        en_q     <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                        gnt_id_q <= winner;
                        busy_q   <= 1'b1;
                        cnt      <= CNT_W'(1);
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state  <= ST_TURN;
                        en_q   <= '0;
                        busy_q <= 1'b0;
                        turn_q <= 1'b1;
                        ptr    <= next_ptr;
                        cnt    <= '0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                    end
                end
                ST_TURN: begin
                    turn_q <= 1'b0;
                    if (found) begin
                        state    <= ST_GRANT;
                        en_q     <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                        gnt_id_q <= winner;
                        busy_q   <= 1'b1;
                        cnt      <= CNT_W'(1);
                    end else begin
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    en_q   <= '0;
                    busy_q <= 1'b0;
                    turn_q <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.en     = en_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = busy_q;
    assign bus.turn   = turn_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tribus_arbiter
// Directed, table-driven bench for tribus_arbiter (N_REQ=4, HOLD_MAX=4).
// Each record holds the inputs applied before a rising edge and the outputs
// expected just after it. Records run back to back, so arbiter state carries
// from one record to the next; scenarios are separated by reset records.
// ----------------------------------------------------------------------------
module tb_tribus_arbiter;

    logic clk;
    logic reset;

    tribus_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

    tribus_arbiter #(
        .N_REQ    (4),
        .HOLD_MAX (4),
        .ID_W     (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] exp_en;
        logic       exp_turn;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(input logic rst, input logic [3:0] req,
                                input logic [3:0] done, input logic [3:0] exp_en,
                                input logic exp_turn, input string name);
        vec_t v;
        v.rst      = rst;
        v.req      = req;
        v.done     = done;
        v.exp_en   = exp_en;
        v.exp_turn = exp_turn;
        v.name     = name;
        vecs.push_back(v);
    endfunction

    function automatic logic [1:0] onehotIndex(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Drive one record's inputs, then let one rising edge go by and settle.
    task automatic applyStimulus(input vec_t v);
        reset    = v.rst;
        bus.req  = v.req;
        bus.done = v.done;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int step, input vec_t v);
        logic exp_busy;
        exp_busy = |v.exp_en;

        total++;
        if (bus.en !== v.exp_en) begin
            bad++;
            $display("[TB] FAIL %s step %0d en: got %b want %b", v.name, step, bus.en, v.exp_en);
        end
        total++;
        if (bus.turn !== v.exp_turn) begin
            bad++;
            $display("[TB] FAIL %s step %0d turn: got %b want %b", v.name, step, bus.turn, v.exp_turn);
        end
        total++;
        if (bus.busy !== exp_busy) begin
            bad++;
            $display("[TB] FAIL %s step %0d busy: got %b want %b", v.name, step, bus.busy, exp_busy);
        end
        total++;
        if (!$onehot0(bus.en)) begin
            bad++;
            $display("[TB] FAIL %s step %0d onehot0: got en=%b want at most one bit", v.name, step, bus.en);
        end
        if (exp_busy) begin
            total++;
            if (bus.gnt_id !== onehotIndex(v.exp_en)) begin
                bad++;
                $display("[TB] FAIL %s step %0d gnt_id: got %0d want %0d", v.name, step, bus.gnt_id, onehotIndex(v.exp_en));
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        bus.req  = 4'b0000;
        bus.done = 4'b0000;

        // Reset held two cycles with everybody requesting, then first grant
        // goes to requester 0 one edge after release.
        add(1, 4'b1111, 4'b0000, 4'b0000, 0, "reset");
        add(1, 4'b1111, 4'b0000, 4'b0000, 0, "reset");
        add(0, 4'b1111, 4'b0000, 4'b0001, 0, "first_grant");

        // Round-robin with everyone requesting: each owner holds for 4
        // cycles, one turnaround cycle, then the next index.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!(r == 0 && c == 0)) begin
                    add(0, 4'b1111, 4'b0000, 4'(1 << r), 0, "rr_hold");
                end
            end
            add(0, 4'b1111, 4'b0000, 4'b0000, 1, "rr_turn");
        end
        add(0, 4'b1111, 4'b0000, 4'b0001, 0, "rr_wrap");

        // Early release by done in the second grant cycle; sole requester is
        // regranted after the turnaround.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, "reset");
        add(0, 4'b0100, 4'b0000, 4'b0100, 0, "early_g1");
        add(0, 4'b0100, 4'b0000, 4'b0100, 0, "early_g2");
        add(0, 4'b0100, 4'b0100, 4'b0000, 1, "early_turn");
        add(0, 4'b0100, 4'b0000, 4'b0100, 0, "early_regrant");

        // Foreign done is ignored; grant runs to the hold limit. The owner's
        // own done during TURN is ignored as well, so it is regranted.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, "reset");
        add(0, 4'b0010, 4'b0000, 4'b0010, 0, "foreign_c1");
        add(0, 4'b0010, 4'b1000, 4'b0010, 0, "foreign_c2");
        add(0, 4'b0010, 4'b1000, 4'b0010, 0, "foreign_c3");
        add(0, 4'b0010, 4'b1000, 4'b0010, 0, "foreign_c4");
        add(0, 4'b0010, 4'b0000, 4'b0000, 1, "foreign_turn");
        add(0, 4'b0010, 4'b0010, 4'b0010, 0, "turn_done_ignored");

        // Owner 3 drops its request: turnaround, idle, then a new request
        // from 0 is granted one cycle later with ptr back at 0.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, "reset");
        add(0, 4'b1000, 4'b0000, 4'b1000, 0, "drop_grant");
        add(0, 4'b0000, 4'b0000, 4'b0000, 1, "drop_turn");
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, "drop_idle");
        add(0, 4'b0000, 4'b0001, 4'b0000, 0, "idle_done_ignored");
        add(0, 4'b1001, 4'b0000, 4'b0001, 0, "idle_ptr0");

        // Reset mid-grant restores ptr to 0.
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, "reset");
        add(0, 4'b0011, 4'b0000, 4'b0001, 0, "mid_g0");
        add(0, 4'b0011, 4'b0001, 4'b0000, 1, "mid_turn");
        add(0, 4'b0011, 4'b0000, 4'b0010, 0, "mid_g1");
        add(1, 4'b0011, 4'b0000, 4'b0000, 0, "mid_reset");
        add(0, 4'b0011, 4'b0000, 4'b0001, 0, "mid_after_reset");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
